sprite_position_tracker: RTL and testbench



---
 rtl/sprite_position_tracker.sv | 187 ++++++++++++++++++
 tb/tb_sprite_position_tracker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sprite_position_tracker.sv
// Frame-synchronous sprite position stage; the hit counter is built only with SPRITE_HIT_COUNT_EN.
// Latency: coordinates commit 4 edges after the v_sync falling-edge sample; frame_tick marks the commit.
// Backpressure: none; a v_sync fall arriving while an update is in flight is dropped, not queued.
module sprite_position_tracker #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SPRITE_SIZE = 16,
    parameter int X_CENTER    = 311,
    parameter int Y_CENTER    = 231,
    parameter int HIT_MAX     = 999
) (
    input  logic       pixel_clk,
    input  logic       reset_n,
    input  logic       v_sync,
    input  logic [9:0] tilt_x,
    input  logic [9:0] tilt_y,
    output logic [9:0] sprite_x1,
    output logic [9:0] sprite_x2,
    output logic [9:0] sprite_y1,
    output logic [9:0] sprite_y2,
    output logic [3:0] at_wall,
    output logic [9:0] hit_count,
    output logic       frame_tick
);

    localparam int X_MAX = H_ACTIVE - SPRITE_SIZE;
    localparam int Y_MAX = V_ACTIVE - SPRITE_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CLAMP_X,
        CLAMP_Y,
        COMMIT
    } state_t;

    state_t     state_q, state_d;
    logic       vs_d_q;
    logic       start;
    logic [9:0] tilt_x_q, tilt_x_d;
    logic [9:0] tilt_y_q, tilt_y_d;
    logic [9:0] x1_new_q, x1_new_d;
    logic [9:0] y1_new_q, y1_new_d;
    logic [9:0] sprite_x1_q, sprite_x1_d;
    logic [9:0] sprite_x2_q, sprite_x2_d;
    logic [9:0] sprite_y1_q, sprite_y1_d;
    logic [9:0] sprite_y2_q, sprite_y2_d;
    logic [3:0] at_wall_q, at_wall_d;
    logic       frame_tick_q, frame_tick_d;
    logic [9:0] x2_new;
    logic [9:0] y2_new;
    logic [3:0] wall_new;

    // Centre plus signed tilt, saturated so the whole sprite stays on screen.
    function automatic logic [9:0] clamp_pos(input logic [9:0] tilt,
                                             input int center,
                                             input int max_pos);
        logic signed [11:0] raw;
        raw = signed'(12'(center)) + signed'({{2{tilt[9]}}, tilt});
        if (raw < 12'sd0) begin
            return 10'd0;
        end else if (raw > signed'(12'(max_pos))) begin
            return 10'(max_pos);
        end else begin
            return raw[9:0];
        end
    endfunction

    assign start    = vs_d_q & ~v_sync;
    assign x2_new   = x1_new_q + 10'(SPRITE_SIZE - 1);
    assign y2_new   = y1_new_q + 10'(SPRITE_SIZE - 1);
    assign wall_new = {y2_new == 10'(V_ACTIVE - 1), y1_new_q == 10'd0,
                       x2_new == 10'(H_ACTIVE - 1), x1_new_q == 10'd0};

    always_comb begin
        state_d      = state_q;
        tilt_x_d     = tilt_x_q;
        tilt_y_d     = tilt_y_q;
        x1_new_d     = x1_new_q;
        y1_new_d     = y1_new_q;
        sprite_x1_d  = sprite_x1_q;
        sprite_x2_d  = sprite_x2_q;
        sprite_y1_d  = sprite_y1_q;
        sprite_y2_d  = sprite_y2_q;
        at_wall_d    = at_wall_q;
        frame_tick_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SAMPLE;
            end
            SAMPLE: begin
                tilt_x_d = tilt_x;
                tilt_y_d = tilt_y;
                state_d  = CLAMP_X;
            end
            CLAMP_X: begin
                x1_new_d = clamp_pos(tilt_x_q, X_CENTER, X_MAX);
                state_d  = CLAMP_Y;
            end
            CLAMP_Y: begin
                y1_new_d = clamp_pos(tilt_y_q, Y_CENTER, Y_MAX);
                state_d  = COMMIT;
            end
            COMMIT: begin
                sprite_x1_d  = x1_new_q;
                sprite_x2_d  = x2_new;
                sprite_y1_d  = y1_new_q;
                sprite_y2_d  = y2_new;
                at_wall_d    = wall_new;
                frame_tick_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            vs_d_q       <= 1'b0;
            tilt_x_q     <= '0;
            tilt_y_q     <= '0;
            x1_new_q     <= 10'(X_CENTER);
            y1_new_q     <= 10'(Y_CENTER);
            sprite_x1_q  <= 10'(X_CENTER);
            sprite_x2_q  <= 10'(X_CENTER + SPRITE_SIZE - 1);
            sprite_y1_q  <= 10'(Y_CENTER);
            sprite_y2_q  <= 10'(Y_CENTER + SPRITE_SIZE - 1);
            at_wall_q    <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_d_q       <= v_sync;
            tilt_x_q     <= tilt_x_d;
            tilt_y_q     <= tilt_y_d;
            x1_new_q     <= x1_new_d;
            y1_new_q     <= y1_new_d;
            sprite_x1_q  <= sprite_x1_d;
            sprite_x2_q  <= sprite_x2_d;
            sprite_y1_q  <= sprite_y1_d;
            sprite_y2_q  <= sprite_y2_d;
            at_wall_q    <= at_wall_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sprite_x1  = sprite_x1_q;
    assign sprite_x2  = sprite_x2_q;
    assign sprite_y1  = sprite_y1_q;
    assign sprite_y2  = sprite_y2_q;
    assign at_wall    = at_wall_q;
    assign frame_tick = frame_tick_q;

`ifdef SPRITE_HIT_COUNT_EN
    logic       prev_contact_q, prev_contact_d;
    logic [9:0] hit_count_q, hit_count_d;
    logic       contact;

    // Only a transition from no contact to contact counts; wall-to-corner slides do not.
    always_comb begin
        prev_contact_d = prev_contact_q;
        hit_count_d    = hit_count_q;
        contact        = |wall_new;
        if (state_q == COMMIT) begin
            prev_contact_d = contact;
            if (contact && !prev_contact_q && (hit_count_q < 10'(HIT_MAX))) begin
                hit_count_d = hit_count_q + 10'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_contact_q <= 1'b0;
            hit_count_q    <= '0;
        end else begin
            prev_contact_q <= prev_contact_d;
            hit_count_q    <= hit_count_d;
        end
    end

    assign hit_count = hit_count_q;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_sprite_position_tracker.sv
// Directed bench for sprite_position_tracker; expected hit counts follow SPRITE_HIT_COUNT_EN.
module tb_sprite_position_tracker;

`ifdef SPRITE_HIT_COUNT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic       pixel_clk;
    logic       reset_n;
    logic       v_sync;
    logic [9:0] tilt_x;
    logic [9:0] tilt_y;
    logic [9:0] sprite_x1, sprite_x2, sprite_y1, sprite_y2;
    logic [3:0] at_wall;
    logic [9:0] hit_count;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;
    int first_tick;
    int nticks;
    int max_hit;
    int idle_ticks;

    sprite_position_tracker dut (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .v_sync    (v_sync),
        .tilt_x    (tilt_x),
        .tilt_y    (tilt_y),
        .sprite_x1 (sprite_x1),
        .sprite_x2 (sprite_x2),
        .sprite_y1 (sprite_y1),
        .sprite_y2 (sprite_y2),
        .at_wall   (at_wall),
        .hit_count (hit_count),
        .frame_tick(frame_tick)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_hits(input int n);
        return HIT_EN ? n : 0;
    endfunction

    task automatic check_out(input string tag, input int x1, input int x2, input int y1,
                             input int y2, input int wall, input int hits);
        check_eq({tag, ".x1"}, 32'(sprite_x1), x1);
        check_eq({tag, ".x2"}, 32'(sprite_x2), x2);
        check_eq({tag, ".y1"}, 32'(sprite_y1), y1);
        check_eq({tag, ".y2"}, 32'(sprite_y2), y2);
        check_eq({tag, ".wall"}, 32'(at_wall), wall);
        check_eq({tag, ".hits"}, 32'(hit_count), exp_hits(hits));
    endtask

    // Starts and ends 1 ns after a rising edge. Cycle n of the loop is sampled just after edge E+n-1.
    task automatic run_frame(input int chg_n, input logic [9:0] chg_tx, input int rst_at,
                             input bit refall, output int first, output int cnt);
        v_sync = 1'b1;
        @(posedge pixel_clk); #1;
        v_sync = 1'b0;
        first = 0;
        cnt   = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge pixel_clk); #1;
            if (n == chg_n) tilt_x = chg_tx;
            if (n == rst_at) reset_n = 1'b0;
            if (refall && n == 1) v_sync = 1'b1;
            if (refall && n == 2) v_sync = 1'b0;
            if (frame_tick) begin
                cnt++;
                if (first == 0) first = n;
            end
        end
    endtask

    task automatic frame(input logic [9:0] tx, input logic [9:0] ty);
        tilt_x = tx;
        tilt_y = ty;
        run_frame(0, '0, 0, 1'b0, first_tick, nticks);
    endtask

    task automatic idle_cycles(output int ticks);
        ticks = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge pixel_clk); #1;
            if (frame_tick) ticks++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        v_sync  = 1'b0;
        tilt_x  = '0;
        tilt_y  = '0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check_out("reset", 311, 326, 231, 246, 0, 0);
        check_eq("reset.tick", 32'(frame_tick), 0);

        reset_n = 1'b1;
        idle_cycles(idle_ticks);
        check_eq("no_start_low_vsync", idle_ticks, 0);

        frame(10'd0, 10'd0);
        check_eq("center.latency", first_tick, 5);
        check_eq("center.tick_len", nticks, 1);
        check_out("center", 311, 326, 231, 246, 0, 0);

        frame(10'(-400), 10'(300));
        check_out("bl_corner", 0, 15, 464, 479, 4'b1001, 1);
        for (int i = 0; i < 3; i++) begin
            frame(10'(-400), 10'(300));
            check_eq("held.hits", 32'(hit_count), exp_hits(1));
        end
        frame(10'd0, 10'd0);
        check_out("back_center", 311, 326, 231, 246, 0, 1);
        frame(10'(400), 10'd0);
        check_out("right", 624, 639, 231, 246, 4'b0010, 2);
        frame(10'(400), 10'(-300));
        check_out("tr_corner", 624, 639, 0, 15, 4'b0110, 2);
        frame(10'(313), 10'(233));
        check_out("exact_max", 624, 639, 464, 479, 4'b1010, 2);
        frame(10'(312), 10'(232));
        check_out("below_max", 623, 638, 463, 478, 4'b0000, 2);
        frame(10'(-311), 10'(-231));
        check_out("exact_min", 0, 15, 0, 15, 4'b0101, 3);

        tilt_x = 10'd10;
        tilt_y = 10'd0;
        run_frame(2, 10'd100, 0, 1'b0, first_tick, nticks);
        check_eq("late_tilt.latency", first_tick, 5);
        check_out("late_tilt", 321, 336, 231, 246, 0, 3);

        tilt_x = 10'd0;
        run_frame(0, '0, 0, 1'b1, first_tick, nticks);
        check_eq("double_fall.ticks", nticks, 1);
        check_out("double_fall", 311, 326, 231, 246, 0, 3);

        max_hit = 0;
        for (int i = 0; i < 2100; i++) begin
            frame((i % 2 == 1) ? 10'(-400) : 10'd0, 10'd0);
            if (int'(hit_count) > max_hit) max_hit = int'(hit_count);
        end
        check_eq("sat.hits", 32'(hit_count), exp_hits(999));
        check_eq("sat.max", max_hit, exp_hits(999));
        check_eq("sat.wall", 32'(at_wall), 4'b0001);

        tilt_x = 10'(-400);
        run_frame(0, '0, 3, 1'b0, first_tick, nticks);
        check_eq("mid_reset.ticks", nticks, 0);
        check_out("mid_reset", 311, 326, 231, 246, 0, 0);
        reset_n = 1'b1;
        idle_cycles(idle_ticks);
        check_eq("post_reset.ticks", idle_ticks, 0);
        check_out("post_reset", 311, 326, 231, 246, 0, 0);

        frame(10'(-400), 10'd0);
        check_eq("after_reset.latency", first_tick, 5);
        check_out("after_reset", 0, 15, 231, 246, 4'b0001, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
